// File: rtl/msk_unshare_seq_if.sv
// Handshake bundle for the share-recombination unit: sharing in, plain value out.
interface msk_unshare_seq_if #(
  parameter int unsigned D     = 2,
  parameter int unsigned COUNT = 1
);
  logic                 in_valid;
  logic                 in_ready;
  logic [COUNT*D-1:0]   in_shares;
  logic                 out_valid;
  logic                 out_ready;
  logic [COUNT-1:0]     out_data;

  // Producer/consumer side (drives the sharing, accepts the plain value)
  modport master (
    output in_valid, in_shares, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Unit side
  modport slave (
    input  in_valid, in_shares, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/msk_unshare_seq.sv
// Serial unmasking unit: folds one Boolean share per cycle into the plain value,
// so no two shares of a bit ever meet in the same combinational cone.
module msk_unshare_seq #(
  parameter int unsigned D     = 2,
  parameter int unsigned COUNT = 1
) (
  input  logic              clk,
  input  logic              syn_rst_n,
  msk_unshare_seq_if.slave  bus,
  output logic              busy
);

  localparam int unsigned W  = COUNT * D;
  localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned NL = 1 << CW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_share;
  logic [COUNT-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  // Share j of every bit, de-interleaved from the stored sharing; unused slots read 0
  logic [COUNT-1:0] w_lane [NL];
  logic [COUNT-1:0] w_in_lane0;

  for (genvar j = 0; j < D; j++) begin : g_lane
    for (genvar i = 0; i < COUNT; i++) begin : g_bit
      assign w_lane[j][i] = r_share[i*D + j];
    end
  end

  for (genvar j = D; j < NL; j++) begin : g_pad
    assign w_lane[j] = '0;
  end

  for (genvar i = 0; i < COUNT; i++) begin : g_in0
    assign w_in_lane0[i] = bus.in_shares[i*D];
  end

  // Control FSM and datapath; every output flag is a register updated with the state
  always_ff @(posedge clk) begin
    if (!syn_rst_n) begin
      r_state     <= S_IDLE;
      r_share     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            // With a single share the accumulator already holds the whole value,
            // so nothing is kept in the share register.
            r_share    <= (D > 1) ? bus.in_shares : '0;
            r_acc      <= w_in_lane0;
            r_cnt      <= (D > 1) ? CW'(1) : '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (D > 1) begin
              r_state <= S_ACC;
            end else begin
              r_state     <= S_OUT;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_ACC: begin
          r_acc <= r_acc ^ w_lane[r_cnt];
          if (r_cnt == CW'(D - 1)) begin
            r_state     <= S_OUT;
            r_share     <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_share     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_share     <= '0;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Plain data only leaves the unit while the FSM is presenting it
  assign bus.out_data  = (r_state == S_OUT) ? r_acc : '0;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign busy          = r_busy;

endmodule

// File: tb/tb_msk_unshare_seq.sv
// Scoreboard bench: four unit instances (d = 1..4, 8 bits) driven with directed
// and random sharings of known plain values.
module tb_msk_unshare_seq;

  localparam int unsigned COUNT   = 8;
  localparam int unsigned NITEMS  = 40;
  localparam int unsigned NDIR    = 6;
  localparam int unsigned RST_IDX = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;
  bit          done [4];

  logic [COUNT-1:0] dir_val [NDIR] = '{8'h5A, 8'h03, 8'hA5, 8'h01, 8'h80, 8'hFF};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name,
                     input longint unsigned act, input longint unsigned exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int unsigned D = g + 1;
    localparam int unsigned W = COUNT * D;

    logic rst_n;
    logic busy;

    msk_unshare_seq_if #(.D(D), .COUNT(COUNT)) bus ();

    msk_unshare_seq #(.D(D), .COUNT(COUNT)) u_dut (
      .clk       (clk),
      .syn_rst_n (rst_n),
      .bus       (bus.slave),
      .busy      (busy)
    );

    logic [COUNT-1:0] exp_q [$];
    int               stall_cnt = 0;
    bit               rnd_mode  = 1'b0;
    int unsigned      acc_cyc   = 0;
    bit               wait_first = 1'b0;
    bit               after_hs   = 1'b0;
    bit               after_rst  = 1'b0;

    // Split plain value v into D shares whose XOR is v, then bit-interleave them
    function automatic logic [W-1:0] make_sharing(input logic [COUNT-1:0] v, input bit directed);
      logic [COUNT-1:0] sh [D];
      logic [W-1:0]     r;
      sh[0] = v;
      for (int j = 1; j < D; j++) begin
        if (directed)
          sh[j] = (j == 1) ? ((D == 2) ? 8'h66 : 8'h05) : ((j == 2) ? 8'h0F : 8'h33);
        else
          sh[j] = COUNT'($urandom);
        sh[0] = sh[0] ^ sh[j];
      end
      r = '0;
      for (int i = 0; i < COUNT; i++)
        for (int j = 0; j < D; j++)
          r[i*D + j] = sh[j][i];
      return r;
    endfunction

    // Stimulus: presents sharings, scribbles on the inputs while the unit is busy
    initial begin
      logic [COUNT-1:0] v;
      bit               dir;
      int               k;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_shares = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int n = 0; n < NITEMS; n++) begin
        dir      = (n < NDIR);
        v        = dir ? dir_val[n] : COUNT'($urandom);
        rnd_mode = !dir;
        while (1) begin
          if (bus.in_ready) begin
            if (rnd_mode && $urandom_range(0, 3) == 0) begin
              bus.in_valid  = 1'b0;
              bus.in_shares = W'($urandom);
            end else begin
              bus.in_valid  = 1'b1;
              bus.in_shares = make_sharing(v, dir);
            end
          end else begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_shares = W'($urandom);
          end
          @(negedge clk);
          if (bus.in_valid && bus.in_ready) break;
          @(posedge clk);
          #1;
        end
        exp_q.push_back(v);
        acc_cyc    = cyc;
        wait_first = 1'b1;
        if (n == 1) stall_cnt = 5;
        @(posedge clk);
        #1;
        if (n == RST_IDX) begin
          k = (D == 4) ? 1 : $urandom_range(0, D - 1);
          repeat (k) begin
            @(posedge clk);
            #1;
          end
          rst_n        = 1'b0;
          bus.in_valid = 1'b0;
          @(posedge clk);
          #1 rst_n = 1'b1;
        end
      end
      bus.in_valid = 1'b0;
      for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(posedge clk);
      chk(exp_q.size() == 0, $sformatf("d%0d drain", D), exp_q.size(), 0);
      repeat (2) @(posedge clk);
      done[g] = 1'b1;
    end

    // Consumer: tied high in the directed phase, random later, one 5-cycle stall
    initial begin
      bus.out_ready = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        if (stall_cnt > 0) begin
          bus.out_ready = 1'b0;
          if (bus.out_valid) stall_cnt--;
        end else begin
          bus.out_ready = rnd_mode ? ($urandom_range(0, 9) < 6) : 1'b1;
        end
      end
    end

    // Monitor: compares every presented output against the scoreboard front
    always @(negedge clk) begin
      if (after_rst) begin
        chk(bus.in_ready == 1'b1,  $sformatf("d%0d reset in_ready", D),  bus.in_ready, 1);
        chk(bus.out_valid == 1'b0, $sformatf("d%0d reset out_valid", D), bus.out_valid, 0);
        chk(bus.out_data == '0,    $sformatf("d%0d reset out_data", D),  bus.out_data, 0);
        chk(busy == 1'b0,          $sformatf("d%0d reset busy", D),      busy, 0);
        after_rst = 1'b0;
      end
      if (after_hs) begin
        chk(bus.in_ready == 1'b1, $sformatf("d%0d in_ready after output", D), bus.in_ready, 1);
        chk(u_dut.r_acc == '0,    $sformatf("d%0d acc cleared", D), longint'(u_dut.r_acc), 0);
        chk(u_dut.r_share == '0,  $sformatf("d%0d share cleared", D), longint'(u_dut.r_share), 0);
        after_hs = 1'b0;
      end
      chk(busy == !bus.in_ready, $sformatf("d%0d busy vs in_ready", D), busy, !bus.in_ready);
      if (!bus.out_valid) begin
        chk(bus.out_data == '0, $sformatf("d%0d out_data gated", D), bus.out_data, 0);
      end else if (exp_q.size() == 0) begin
        chk(1'b0, $sformatf("d%0d unexpected out_valid", D), 1, 0);
      end else begin
        if (wait_first) begin
          chk(cyc - acc_cyc == D, $sformatf("d%0d latency", D), cyc - acc_cyc, D);
          wait_first = 1'b0;
        end
        chk(bus.out_data == exp_q[0], $sformatf("d%0d out_data", D), bus.out_data, exp_q[0]);
        chk(bus.in_ready == 1'b0, $sformatf("d%0d in_ready in OUT", D), bus.in_ready, 0);
        chk(u_dut.r_share == '0, $sformatf("d%0d share zero in OUT", D), longint'(u_dut.r_share), 0);
        if (bus.out_ready && rst_n) begin
          void'(exp_q.pop_front());
          after_hs = 1'b1;
        end
      end
      if (!rst_n) begin
        exp_q.delete();
        wait_first = 1'b0;
        after_hs   = 1'b0;
        after_rst  = 1'b1;
      end
    end
  end

  // Global completion with a hard cycle bound
  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int t = 0; t < 20000 && !all_done; t++) begin
      @(posedge clk);
      all_done = done[0] && done[1] && done[2] && done[3];
    end
    chk(all_done, "completion", all_done, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
